// File: rtl/key_debounce_scheduler.sv
// rtl/key_debounce_scheduler.sv - shared settle counter debouncer for keyboard keys (option macro: KEY_DEBOUNCE_SYNC_EN)
module key_debounce_scheduler #(
  parameter int NUM_KEYS    = 8,
  parameter int SETTLE_BITS = 16,
  parameter int IDX_W       = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic                busy,
  output logic [IDX_W-1:0]    active_idx
);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_SETTLE,
    ST_COMMIT
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SETTLE_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]    key_state_q, key_state_d;
  logic [NUM_KEYS-1:0]    press_q, press_d;
  logic [NUM_KEYS-1:0]    release_q, release_d;
  logic [NUM_KEYS-1:0]    key_sync;

`ifdef KEY_DEBOUNCE_SYNC_EN
  logic [NUM_KEYS-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for the asynchronous key inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  assign key_sync = sync2_q;
`else
  assign key_sync = key_raw;
`endif

  // Round-robin successor of a key index
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_KEYS - 1)) begin
      next_idx = '0;
    end else begin
      next_idx = i + 1'b1;
    end
  endfunction

  // State register for scan pointer, owner, settle counter and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      ptr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '1;
      key_state_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  // Scan for a disagreeing key, let it own the counter, commit or abort
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    key_state_d = key_state_q;
    press_d     = '0;
    release_d   = '0;
    case (state_q)
      ST_SCAN: begin
        if (key_sync[ptr_q] != key_state_q[ptr_q]) begin
          idx_d   = ptr_q;
          cnt_d   = '1;
          state_d = ST_SETTLE;
        end else begin
          ptr_d = next_idx(ptr_q);
        end
      end
      ST_SETTLE: begin
        if (key_sync[idx_q] == key_state_q[idx_q]) begin
          // Bounced back to the debounced level: give up, move past this key
          ptr_d   = next_idx(idx_q);
          state_d = ST_SCAN;
        end else if (cnt_q == '0) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_COMMIT: begin
        key_state_d[idx_q] = ~key_state_q[idx_q];
        if (!key_state_q[idx_q]) begin
          press_d[idx_q] = 1'b1;
        end else begin
          release_d[idx_q] = 1'b1;
        end
        ptr_d   = next_idx(idx_q);
        state_d = ST_SCAN;
      end
      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  assign key_state     = key_state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign busy          = (state_q != ST_SCAN);
  assign active_idx    = idx_q;

endmodule

// File: tb/tb_key_debounce_scheduler.sv
// tb/tb_key_debounce_scheduler.sv - self-checking bench for key_debounce_scheduler
module tb_key_debounce_scheduler;

  localparam int N   = 4;
  localparam int SB  = 4;
  localparam int WIN = 1 << SB;
`ifdef KEY_DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk;
  logic         reset;
  logic [N-1:0] key_raw;
  logic [N-1:0] key_state;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic         busy;
  logic [1:0]   active_idx;

  int checks   = 0;
  int failures = 0;

  key_debounce_scheduler #(
    .NUM_KEYS    (N),
    .SETTLE_BITS (SB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_raw       (key_raw),
    .key_state     (key_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .busy          (busy),
    .active_idx    (active_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: sync delay as a history of sampled inputs,
  // a settle claim counted up in held cycles
  logic [N-1:0] hist [0:1];
  logic [N-1:0] ks;
  logic [N-1:0] m_state, m_press, m_rel;
  bit           m_busy, m_commit;
  int           m_own, m_ptr, m_held;

  task automatic model_reset();
    hist[0]  = '0;
    hist[1]  = '0;
    m_state  = '0;
    m_press  = '0;
    m_rel    = '0;
    m_busy   = 1'b0;
    m_commit = 1'b0;
    m_own    = 0;
    m_ptr    = 0;
    m_held   = 0;
  endtask

  task automatic model_step();
`ifdef KEY_DEBOUNCE_SYNC_EN
    ks = hist[1];
`else
    ks = key_raw;
`endif
    hist[1] = hist[0];
    hist[0] = key_raw;
    m_press = '0;
    m_rel   = '0;
    if (!m_busy) begin
      if (ks[m_ptr] != m_state[m_ptr]) begin
        m_busy   = 1'b1;
        m_own    = m_ptr;
        m_held   = 0;
        m_commit = 1'b0;
      end else begin
        m_ptr = (m_ptr + 1) % N;
      end
    end else if (m_commit) begin
      m_state[m_own] = ~m_state[m_own];
      if (m_state[m_own]) m_press[m_own] = 1'b1;
      else m_rel[m_own] = 1'b1;
      m_busy   = 1'b0;
      m_commit = 1'b0;
      m_ptr    = (m_own + 1) % N;
    end else if (ks[m_own] == m_state[m_own]) begin
      m_busy = 1'b0;
      m_ptr  = (m_own + 1) % N;
    end else begin
      m_held = m_held + 1;
      if (m_held == WIN) m_commit = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, plus pulse bookkeeping
  int npress [N];
  int nrel   [N];
  int tp     [N];
  int cyc      = 0;
  int busy_cnt = 0;

  initial begin
    for (int k = 0; k < N; k++) begin
      npress[k] = 0;
      nrel[k]   = 0;
      tp[k]     = 0;
    end
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      chk("model_key_state", 32'(key_state), 32'(m_state));
      chk("model_press", 32'(press_pulse), 32'(m_press));
      chk("model_release", 32'(release_pulse), 32'(m_rel));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_active_idx", 32'(active_idx), 32'(m_own));
      if (busy) busy_cnt = busy_cnt + 1;
      for (int k = 0; k < N; k++) begin
        if (press_pulse[k]) begin
          npress[k] = npress[k] + 1;
          tp[k]     = cyc;
        end
        if (release_pulse[k]) nrel[k] = nrel[k] + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int p1, p3, p0, r0, bc, tot;
  bit found;

  initial begin
    reset   = 1'b1;
    key_raw = 4'b1111;
    tick(3);
    chk("rst_key_state", 32'(key_state), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_press", 32'(press_pulse), 32'h0);
    chk("rst_release", 32'(release_pulse), 32'h0);
    chk("rst_active_idx", 32'(active_idx), 32'h0);

    reset = 1'b0;
    tick(LAT);
    chk("busy_before_detect", 32'(busy), 32'h0);
    tick(1);
    chk("busy_after_detect", 32'(busy), 32'h1);
    chk("first_owner", 32'(active_idx), 32'h0);
    tick(100);
    chk("all_pressed", 32'(key_state), 32'hf);
    key_raw = 4'b0000;
    tick(100);
    chk("all_released", 32'(key_state), 32'h0);

    // Clean press on key 0 with the scan pointer arriving exactly on it
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(4 - LAT);
    key_raw = 4'b0001;
    tick(LAT + 17);
    chk("press_pending_state", 32'(key_state), 32'h0);
    chk("press_pending_busy", 32'(busy), 32'h1);
    chk("press_owner", 32'(active_idx), 32'h0);
    tick(1);
    chk("press_state", 32'(key_state), 32'h1);
    chk("press_pulse_hi", 32'(press_pulse), 32'h1);
    tick(1);
    chk("press_pulse_lo", 32'(press_pulse), 32'h0);
    chk("press_busy_lo", 32'(busy), 32'h0);

    // Bounce on key 2: claims the counter, then aborts without a pulse
    p0 = npress[2];
    bc = busy_cnt;
    key_raw = 4'b0101;
    tick(5);
    key_raw = 4'b0001;
    tick(15);
    chk("bounce_busy", 32'(busy), 32'h0);
    chk("bounce_state", 32'(key_state), 32'h1);
    chk("bounce_no_pulse", 32'(npress[2] - p0), 32'h0);
    chk("bounce_claimed", 32'(busy_cnt > bc), 32'h1);

    // Fairness: keys 1 and 3 rise together, key 1 is reached first
    reset   = 1'b1;
    key_raw = 4'b0000;
    tick(1);
    reset = 1'b0;
    tick(4 - LAT);
    p1 = npress[1];
    p3 = npress[3];
    key_raw = 4'b1010;
    tick(60);
    chk("fair_key1_once", 32'(npress[1] - p1), 32'h1);
    chk("fair_key3_once", 32'(npress[3] - p3), 32'h1);
    chk("fair_gap", 32'(tp[3] - tp[1]), 32'd19);
    chk("fair_state", 32'(key_state), 32'ha);

    // Press then release key 0
    p0 = npress[0];
    r0 = nrel[0];
    key_raw = 4'b1011;
    tick(40);
    key_raw = 4'b1010;
    tick(40);
    chk("rel_press_once", 32'(npress[0] - p0), 32'h1);
    chk("rel_release_once", 32'(nrel[0] - r0), 32'h1);
    chk("rel_state", 32'(key_state), 32'ha);

    // Reset in the middle of a settle window
    key_raw = 4'b1110;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (busy) found = 1'b1;
    end
    chk("mid_claim_seen", 32'(found), 32'h1);
    chk("mid_owner", 32'(active_idx), 32'h2);
    tick(8);
    chk("mid_busy_cnt7", 32'(busy), 32'h1);
    tot = 0;
    for (int k = 0; k < N; k++) tot = tot + npress[k] + nrel[k];
    key_raw = 4'b1111;
    reset   = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_state", 32'(key_state), 32'h0);
    tick(2);
    for (int k = 0; k < N; k++) tot = tot - npress[k] - nrel[k];
    chk("mid_rst_no_pulse", 32'(tot), 32'h0);
    reset = 1'b0;
    tick(LAT + 1);
    chk("restart_busy", 32'(busy), 32'h1);
    chk("restart_owner", 32'(active_idx), 32'h0);
    tick(100);
    chk("restart_all_pressed", 32'(key_state), 32'hf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
